// File: rtl/mem_stage.sv
// MEM stage: waits for the data-SRAM response, shapes load data and
// builds the WB bus; drops stale responses left behind by flushes.
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ws_allowin,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [173:0] es_to_ms_bus,
    output logic         ms_to_ws_valid,
    output logic [167:0] ms_to_ws_bus,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    output logic [4:0]   ms_to_ds_dest,
    output logic [31:0]  ms_to_ds_value,
    output logic         ms_to_ds_load_wait,
    output logic         ms_ex,
    output logic         ms_csr,
    input  logic         ws_reflush_ms
);

    logic         ms_valid_q, ms_valid_d;
    logic [173:0] bus_q, bus_d;
    logic         buf_valid_q, buf_valid_d;
    logic [31:0]  buf_q, buf_d;
    logic [1:0]   discard_cnt_q, discard_cnt_d;

    logic         req_issued;
    logic [4:0]   ld_op;
    logic         ertn;
    logic         csr_we;
    logic         csr_rd;
    logic [16:0]  ex_cause;
    logic         gr_we;
    logic [4:0]   dest;
    logic [31:0]  final_result;
    logic         has_ex;
    logic         gr_we_out;

    assign req_issued   = bus_q[173];
    assign ld_op        = bus_q[172:168];
    assign ertn         = bus_q[135];
    assign csr_we       = bus_q[134];
    assign csr_rd       = bus_q[133];
    assign ex_cause     = bus_q[86:70];
    assign gr_we        = bus_q[69];
    assign dest         = bus_q[68:64];
    assign final_result = bus_q[63:32];
    assign has_ex       = |ex_cause;
    assign gr_we_out    = gr_we && !has_ex;

    logic data_ok_eff;
    logic ms_ready_go;
    logic ms_leave;
    logic buf_capture;
    logic discard_inc;
    logic discard_dec;

    // A response is ours only once every flushed request has been answered
    assign data_ok_eff = data_sram_data_ok && (discard_cnt_q == 2'd0);
    assign ms_ready_go = !req_issued || buf_valid_q || data_ok_eff;
    assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_leave    = ms_valid_q && ms_ready_go && ws_allowin;
    assign buf_capture = ms_valid_q && req_issued && !buf_valid_q
                         && data_ok_eff && !ws_allowin;
    assign discard_inc = ws_reflush_ms && ms_valid_q && req_issued
                         && !buf_valid_q && !data_ok_eff;
    assign discard_dec = data_sram_data_ok && (discard_cnt_q != 2'd0);

    logic [31:0] raw;
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [31:0] result;

    assign raw  = buf_valid_q ? buf_q : data_sram_rdata;
    assign sh_b = raw >> {final_result[1:0], 3'b000};
    assign sh_h = raw >> {final_result[1], 4'b0000};

    always_comb begin
        result = final_result;
        if (!has_ex) begin
            unique case (1'b1)
                ld_op[0]: result = {{24{sh_b[7]}}, sh_b[7:0]};
                ld_op[1]: result = {24'd0, sh_b[7:0]};
                ld_op[2]: result = {{16{sh_h[15]}}, sh_h[15:0]};
                ld_op[3]: result = {16'd0, sh_h[15:0]};
                ld_op[4]: result = raw;
                default:  result = final_result;
            endcase
        end
    end

    assign ms_to_ws_valid     = ms_valid_q && ms_ready_go && !ws_reflush_ms;
    assign ms_to_ws_bus       = {bus_q[167:70], gr_we_out, dest,
                                 result, bus_q[31:0]};
    assign ms_to_ds_dest      = (ms_valid_q && gr_we_out) ? dest : 5'd0;
    assign ms_to_ds_value     = result;
    assign ms_to_ds_load_wait = ms_valid_q && (|ld_op) && !ms_ready_go;
    assign ms_ex              = ms_valid_q && (has_ex || ertn);
    assign ms_csr             = ms_valid_q && (csr_we || csr_rd);

    always_comb begin
        ms_valid_d    = ms_valid_q;
        bus_d         = bus_q;
        buf_valid_d   = buf_valid_q;
        buf_d         = buf_q;
        discard_cnt_d = discard_cnt_q;

        if (ws_reflush_ms) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        if (es_to_ms_valid && ms_allowin && !ws_reflush_ms) begin
            bus_d = es_to_ms_bus;
        end

        if (ws_reflush_ms || ms_leave) begin
            buf_valid_d = 1'b0;
        end else if (buf_capture) begin
            buf_valid_d = 1'b1;
            buf_d       = data_sram_rdata;
        end

        if (discard_inc && !discard_dec && discard_cnt_q != 2'd3) begin
            discard_cnt_d = discard_cnt_q + 2'd1;
        end else if (discard_dec && !discard_inc) begin
            discard_cnt_d = discard_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q    <= 1'b0;
            bus_q         <= '0;
            buf_valid_q   <= 1'b0;
            buf_q         <= '0;
            discard_cnt_q <= 2'd0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            bus_q         <= bus_d;
            buf_valid_q   <= buf_valid_d;
            buf_q         <= buf_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

endmodule
